// File: rtl/dds_freq_ctrl_if.sv
// Front-panel bundle between the key debouncers / DDS core and the
// frequency controller. Keys are active-low debounced levels; every
// output is registered inside the controller.
interface dds_freq_ctrl_if #(
  parameter int FW_W   = 32,
  parameter int WAVE_W = 2
);
  logic              key_plus;
  logic              key_minus;
  logic              key_wave;
  logic              key_step;
  logic [FW_W-1:0]   fword;
  logic [WAVE_W-1:0] wave_sel;
  logic [1:0]        step_idx;
  logic              fword_upd;
  logic              at_max;
  logic              at_min;

  // Panel side: drives the keys, observes the controller outputs
  modport master (
    output key_plus, key_minus, key_wave, key_step,
    input  fword, wave_sel, step_idx, fword_upd, at_max, at_min
  );

  // Controller side
  modport slave (
    input  key_plus, key_minus, key_wave, key_step,
    output fword, wave_sel, step_idx, fword_upd, at_max, at_min
  );
endinterface

// File: rtl/dds_freq_ctrl.sv
// DDS front-panel controller: turns debounced key levels into a
// saturating frequency control word (x1/x10/x100 step, long-press
// auto-repeat), a waveform selector and a step-size selector.
module dds_freq_ctrl #(
  parameter int          FW_W       = 32,
  parameter int unsigned FWORD_UNIT = 85899,
  parameter int unsigned FWORD_INIT = 85899,
  parameter int unsigned FWORD_MIN  = 85899,
  parameter int unsigned FWORD_MAX  = 8589935,
  parameter int          WAVE_NUM   = 3,
  parameter int          WAVE_W     = 2,
  parameter int          REPEAT_DLY = 25000000,
  parameter int          REPEAT_PER = 5000000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  dds_freq_ctrl_if.slave   bus
);

  localparam int WIDE_W  = FW_W + 8;
  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [WIDE_W-1:0] STEP_X1   = WIDE_W'(FWORD_UNIT);
  localparam logic [WIDE_W-1:0] STEP_X10  = WIDE_W'(FWORD_UNIT) * WIDE_W'(10);
  localparam logic [WIDE_W-1:0] STEP_X100 = WIDE_W'(FWORD_UNIT) * WIDE_W'(100);
  localparam logic [WIDE_W-1:0] MAX_WIDE  = WIDE_W'(FWORD_MAX);
  localparam logic [WIDE_W-1:0] MIN_WIDE  = WIDE_W'(FWORD_MIN);
  localparam logic [FW_W-1:0]   FW_INIT   = FW_W'(FWORD_INIT);
  localparam logic [FW_W-1:0]   FW_MAX    = FW_W'(FWORD_MAX);
  localparam logic [FW_W-1:0]   FW_MIN    = FW_W'(FWORD_MIN);
  localparam logic [WAVE_W-1:0] WAVE_LAST = WAVE_W'(WAVE_NUM - 1);
  localparam logic [CNT_W-1:0]  DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0]  PER_LAST  = CNT_W'(REPEAT_PER - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } rptState_t;

  // Key bit order: [0]=plus [1]=minus [2]=wave [3]=step, 0 = pressed
  logic [3:0]        keyNow;
  logic [3:0]        keyPrev_q;
  logic [3:0]        keyLock_q, keyLock_d;
  logic [3:0]        pressEv;

  logic [FW_W-1:0]   fword_q, fword_d;
  logic [WAVE_W-1:0] waveSel_q, waveSel_d;
  logic [1:0]        stepIdx_q, stepIdx_d;
  logic              fwordUpd_q;
  logic              atMax_q;
  logic              atMin_q;

  rptState_t         rptState_q, rptState_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dirUp_q, dirUp_d;

  logic              plusDown, minusDown, bothDown, heldDown;
  logic              doUp, doDown;
  logic [WIDE_W-1:0] stepWide, fwordWide, sumWide, upWide, downWide;

  assign keyNow    = {bus.key_step, bus.key_wave, bus.key_minus, bus.key_plus};
  // A key held through reset stays locked until it is seen released, so it
  // cannot masquerade as a fresh press once reset lifts.
  assign pressEv   = ~keyNow & keyPrev_q & ~keyLock_q;
  assign keyLock_d = keyLock_q & ~keyNow;

  assign plusDown  = ~keyNow[0];
  assign minusDown = ~keyNow[1];
  assign bothDown  = plusDown & minusDown;
  assign heldDown  = dirUp_q ? plusDown : minusDown;

  // Current step size taken from the registered step selector
  always_comb begin
    stepWide = STEP_X1;
    case (stepIdx_q)
      2'd1:    stepWide = STEP_X10;
      2'd2:    stepWide = STEP_X100;
      default: stepWide = STEP_X1;
    endcase
  end

  // Wide arithmetic so the saturation compares can never overflow
  assign fwordWide = {8'd0, fword_q};
  assign sumWide   = fwordWide + stepWide;
  assign upWide    = (sumWide > MAX_WIDE) ? MAX_WIDE : sumWide;
  assign downWide  = (fwordWide >= (stepWide + MIN_WIDE)) ? (fwordWide - stepWide) : MIN_WIDE;

  // Shared plus/minus repeat FSM: decides when a step is applied this cycle
  always_comb begin
    rptState_d = rptState_q;
    cnt_d      = cnt_q;
    dirUp_d    = dirUp_q;
    doUp       = 1'b0;
    doDown     = 1'b0;
    if (bothDown) begin
      rptState_d = RPT_IDLE;
      cnt_d      = '0;
    end else if (pressEv[0] || pressEv[1]) begin
      doUp       = pressEv[0];
      doDown     = pressEv[1];
      dirUp_d    = pressEv[0];
      rptState_d = RPT_HOLD;
      cnt_d      = '0;
    end else if (rptState_q != RPT_IDLE) begin
      if (!heldDown) begin
        rptState_d = RPT_IDLE;
        cnt_d      = '0;
      end else if (rptState_q == RPT_HOLD) begin
        if (cnt_q == DLY_LAST) begin
          doUp       = dirUp_q;
          doDown     = ~dirUp_q;
          rptState_d = RPT_REPEAT;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        if (cnt_q == PER_LAST) begin
          doUp   = dirUp_q;
          doDown = ~dirUp_q;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Next values for the frequency word, waveform and step selectors
  always_comb begin
    fword_d = fword_q;
    if (doUp) begin
      fword_d = upWide[FW_W-1:0];
    end else if (doDown) begin
      fword_d = downWide[FW_W-1:0];
    end
    waveSel_d = waveSel_q;
    if (pressEv[2]) begin
      waveSel_d = (waveSel_q == WAVE_LAST) ? '0 : waveSel_q + WAVE_W'(1);
    end
    stepIdx_d = stepIdx_q;
    if (pressEv[3]) begin
      stepIdx_d = (stepIdx_q == 2'd2) ? 2'd0 : stepIdx_q + 2'd1;
    end
  end

  // All state and registered outputs, synchronous active-low reset
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      keyPrev_q  <= '1;
      keyLock_q  <= ~keyNow;
      fword_q    <= FW_INIT;
      waveSel_q  <= '0;
      stepIdx_q  <= 2'd0;
      fwordUpd_q <= 1'b0;
      atMax_q    <= (FW_INIT == FW_MAX);
      atMin_q    <= (FW_INIT == FW_MIN);
      rptState_q <= RPT_IDLE;
      cnt_q      <= '0;
      dirUp_q    <= 1'b1;
    end else begin
      keyPrev_q  <= keyNow;
      keyLock_q  <= keyLock_d;
      fword_q    <= fword_d;
      waveSel_q  <= waveSel_d;
      stepIdx_q  <= stepIdx_d;
      fwordUpd_q <= (fword_d != fword_q);
      atMax_q    <= (fword_d == FW_MAX);
      atMin_q    <= (fword_d == FW_MIN);
      rptState_q <= rptState_d;
      cnt_q      <= cnt_d;
      dirUp_q    <= dirUp_d;
    end
  end

  assign bus.fword     = fword_q;
  assign bus.wave_sel  = waveSel_q;
  assign bus.step_idx  = stepIdx_q;
  assign bus.fword_upd = fwordUpd_q;
  assign bus.at_max    = atMax_q;
  assign bus.at_min    = atMin_q;

endmodule

// File: tb/tb_dds_freq_ctrl.sv
// Directed bench for dds_freq_ctrl with small parameters: a table of
// single-cycle key vectors plus hand-written hold, both-keys and
// reset-during-repeat sequences.
module tb_dds_freq_ctrl;

  typedef struct {
    bit p, m, w, s;
    int fw, wv, st;
    bit upd, mx, mn;
  } vec_t;

  logic sysClk;
  logic rstN;
  int   checks;
  int   errors;
  int   nSteps;
  bit   stepNow;
  vec_t vecs[$];

  dds_freq_ctrl_if #(.FW_W(32), .WAVE_W(2)) bus ();

  dds_freq_ctrl #(
    .FW_W(32), .FWORD_UNIT(100), .FWORD_INIT(100), .FWORD_MIN(100),
    .FWORD_MAX(1000), .WAVE_NUM(3), .WAVE_W(2), .REPEAT_DLY(8), .REPEAT_PER(4)
  ) dut (
    .sys_clk(sysClk),
    .rst_n(rstN),
    .bus(bus)
  );

  // Free-running 10 ns clock
  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  task automatic addVec(input bit p, m, w, s, input int fw, wv, st, input bit upd, mx, mn);
    vec_t v;
    v.p = p; v.m = m; v.w = w; v.s = s;
    v.fw = fw; v.wv = wv; v.st = st;
    v.upd = upd; v.mx = mx; v.mn = mn;
    vecs.push_back(v);
  endtask

  // Drive key levels (1 = pressed here), then step one clock and settle
  task automatic applyStimulus(input bit p, m, w, s);
    bus.key_plus  = ~p;
    bus.key_minus = ~m;
    bus.key_wave  = ~w;
    bus.key_step  = ~s;
    @(posedge sysClk);
    #1;
  endtask

  task automatic checkField(input string name, input string field, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int fw, wv, st, input bit upd, mx, mn);
    checkField(name, "fword", bus.fword, fw);
    checkField(name, "wave_sel", 32'(bus.wave_sel), wv);
    checkField(name, "step_idx", 32'(bus.step_idx), st);
    checkField(name, "fword_upd", 32'(bus.fword_upd), 32'(upd));
    checkField(name, "at_max", 32'(bus.at_max), 32'(mx));
    checkField(name, "at_min", 32'(bus.at_min), 32'(mn));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstN   = 1'b0;
    bus.key_plus = 1'b1; bus.key_minus = 1'b1; bus.key_wave = 1'b1; bus.key_step = 1'b1;

    // Single-cycle press/release vectors
    addVec(1,0,0,0, 200,0,0, 1,0,0);
    addVec(0,0,0,0, 200,0,0, 0,0,0);
    addVec(0,0,0,1, 200,0,1, 0,0,0);
    addVec(0,0,0,0, 200,0,1, 0,0,0);
    addVec(1,0,0,0, 1000,0,1, 1,1,0);
    addVec(0,0,0,0, 1000,0,1, 0,1,0);
    for (int i = 0; i < 8; i++) begin
      addVec(1,0,0,0, 1000,0,1, 0,1,0);
      addVec(0,0,0,0, 1000,0,1, 0,1,0);
    end
    addVec(0,1,0,0, 100,0,1, 1,0,1);
    addVec(0,0,0,0, 100,0,1, 0,0,1);
    for (int i = 0; i < 19; i++) begin
      addVec(0,1,0,0, 100,0,1, 0,0,1);
      addVec(0,0,0,0, 100,0,1, 0,0,1);
    end
    addVec(0,0,0,1, 100,0,2, 0,0,1);
    addVec(0,0,0,0, 100,0,2, 0,0,1);
    addVec(0,0,0,1, 100,0,0, 0,0,1);
    addVec(0,0,0,0, 100,0,0, 0,0,1);
    addVec(0,0,1,0, 100,1,0, 0,0,1);
    addVec(0,0,0,0, 100,1,0, 0,0,1);
    addVec(0,0,1,0, 100,2,0, 0,0,1);
    addVec(0,0,0,0, 100,2,0, 0,0,1);
    addVec(0,0,1,0, 100,0,0, 0,0,1);
    addVec(0,0,0,0, 100,0,0, 0,0,1);
    addVec(1,0,1,0, 200,1,0, 1,0,0);
    addVec(0,0,0,0, 200,1,0, 0,0,0);
    addVec(1,0,0,1, 300,1,1, 1,0,0);
    addVec(0,0,0,0, 300,1,1, 0,0,0);
    addVec(0,0,0,1, 300,1,2, 0,0,0);
    addVec(0,0,0,0, 300,1,2, 0,0,0);
    addVec(0,0,0,1, 300,1,0, 0,0,0);
    addVec(0,0,0,0, 300,1,0, 0,0,0);
    addVec(0,1,0,0, 200,1,0, 1,0,0);
    addVec(0,0,0,0, 200,1,0, 0,0,0);
    addVec(0,1,0,0, 100,1,0, 1,0,1);
    addVec(0,0,0,0, 100,1,0, 0,0,1);
    addVec(1,1,0,0, 100,1,0, 0,0,1);
    addVec(0,0,0,0, 100,1,0, 0,0,1);

    repeat (2) @(posedge sysClk);
    #1;
    checkOutput("reset", 100, 0, 0, 0, 0, 1);
    rstN = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].p, vecs[i].m, vecs[i].w, vecs[i].s);
      checkOutput($sformatf("vec%0d", i), vecs[i].fw, vecs[i].wv, vecs[i].st,
                  vecs[i].upd, vecs[i].mx, vecs[i].mn);
    end

    // Long press: step at press, again 8 cycles later, then every 4 cycles
    nSteps = 0;
    for (int k = 0; k < 20; k++) begin
      stepNow = (k == 0) || (k == 8) || (k > 8 && ((k - 8) % 4) == 0);
      applyStimulus(1,0,0,0);
      if (stepNow) nSteps++;
      checkOutput($sformatf("hold k%0d", k), 100 + 100 * nSteps, 1, 0, stepNow, 0, 0);
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0,0,0,0);
      checkOutput($sformatf("release k%0d", k), 500, 1, 0, 0, 0, 0);
    end

    // Both keys together: nothing moves, no repeat
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1,1,0,0);
      checkOutput($sformatf("both k%0d", k), 500, 1, 0, 0, 0, 0);
    end
    applyStimulus(0,0,0,0);
    checkOutput("both release", 500, 1, 0, 0, 0, 0);
    applyStimulus(1,0,0,0);
    checkOutput("plus before both", 600, 1, 0, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1,1,0,0);
      checkOutput($sformatf("plus+minus k%0d", k), 600, 1, 0, 0, 0, 0);
    end
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1,0,0,0);
      checkOutput($sformatf("plus after both k%0d", k), 600, 1, 0, 0, 0, 0);
    end
    applyStimulus(0,0,0,0);
    checkOutput("idle", 600, 1, 0, 0, 0, 0);

    // Reset while in REPEAT with plus still held
    applyStimulus(0,0,0,1);
    checkOutput("step x10", 600, 1, 1, 0, 0, 0);
    applyStimulus(0,0,0,0);
    checkOutput("step release", 600, 1, 1, 0, 0, 0);
    applyStimulus(1,0,0,0);
    checkOutput("hold to max", 1000, 1, 1, 1, 1, 0);
    for (int k = 1; k < 12; k++) begin
      applyStimulus(1,0,0,0);
      checkOutput($sformatf("hold at max k%0d", k), 1000, 1, 1, 0, 1, 0);
    end
    rstN = 1'b0;
    applyStimulus(1,0,0,0);
    checkOutput("reset in repeat", 100, 0, 0, 0, 0, 1);
    rstN = 1'b1;
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1,0,0,0);
      checkOutput($sformatf("held after reset k%0d", k), 100, 0, 0, 0, 0, 1);
    end
    applyStimulus(0,0,0,0);
    checkOutput("release after reset", 100, 0, 0, 0, 0, 1);
    applyStimulus(1,0,0,0);
    checkOutput("repress after reset", 200, 0, 0, 1, 0, 0);
    applyStimulus(0,0,0,0);
    checkOutput("final release", 200, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_freq_ctrl.md
Name: dds_freq_ctrl

Overview:
Parametrised front-panel controller for the DDS signal generator. It turns debounced key levels into a frequency control word and a waveform selector for the DDS core.
- Adds a selectable step size (x1/x10/x100).
- Adds saturating min/max limits instead of wrap-around.
- Adds long-press auto-repeat.
- Supports a parametrised number of waveforms.

Sits between the key debouncers and the DDS phase accumulator.

Parameters:
FW_W, 32, frequency word width
FWORD_UNIT, 85899, word increment for 1 kHz at 50 MHz sys_clk
FWORD_INIT, 85899, fword reset value (must lie within FWORD_MIN..FWORD_MAX)
FWORD_MIN, 85899, lower saturation limit
FWORD_MAX, 8589935, upper saturation limit (100 kHz)
WAVE_NUM, 3, number of waveforms (>=2)
WAVE_W, 2, width of wave_sel (>= clog2(WAVE_NUM))
REPEAT_DLY, 25000000, hold cycles before auto-repeat starts (0.5 s)
REPEAT_PER, 5000000, cycles between auto-repeat steps (100 ms)

Ports:
sys_clk  in  1  system clock; the only clock
rst_n  in  1  synchronous reset, active-low
key_plus  in  1  debounced level, 0 = pressed; raise frequency
key_minus  in  1  debounced level, 0 = pressed; lower frequency
key_wave  in  1  debounced level, 0 = pressed; next waveform
key_step  in  1  debounced level, 0 = pressed; next step size
fword  out  FW_W  frequency control word to DDS
wave_sel  out  WAVE_W  waveform index, 0..WAVE_NUM-1
step_idx  out  2  0 = x1, 1 = x10, 2 = x100 FWORD_UNIT
fword_upd  out  1  one-cycle pulse when fword changes value
at_max  out  1  fword == FWORD_MAX
at_min  out  1  fword == FWORD_MIN

Behaviour:
- Reset (sampled on sys_clk rising edge with rst_n=0):
  - fword=FWORD_INIT, wave_sel=0, step_idx=0, fword_upd=0.
  - All key-history registers set to 1 (released), so no false press event at reset release.
  - Repeat FSM returns to IDLE and its counter clears.
  - Reset mid-hold cancels the repeat; the still-held key generates no event until it is released and pressed again.
- Press event: a key sampled 0 while its previous sample was 1. Outputs update on that same edge, i.e. 1-cycle latency from the input falling.
- Step value STEP = FWORD_UNIT * {1, 10, 100}[step_idx]. Arithmetic is done in FW_W+8 bits.
- Plus: fword <= min(fword+STEP, FWORD_MAX). Minus: fword <= max(fword-STEP, FWORD_MIN). Never wraps.
- fword_upd=1 only when the new value differs from the old one. A press while already saturated gives no pulse.
- Plus and minus both pressed/held: no fword change; repeat FSM forced to IDLE.
- key_wave event: wave_sel increments, wrapping WAVE_NUM-1 -> 0.
- key_step event: step_idx cycles 0 -> 1 -> 2 -> 0.
- Channels are independent; wave, step and frequency events in the same cycle all take effect. A frequency change in the same cycle as a step event uses the old step_idx.
- Auto-repeat FSM (shared by plus/minus, one counter):
  - IDLE: on a plus or minus press event (only one key), apply the step, clear the counter, go to HOLD.
  - HOLD: counter increments while the same key is held. When it reaches REPEAT_DLY-1: apply one step, clear the counter, go to REPEAT.
  - REPEAT: when the counter reaches REPEAT_PER-1: apply a step, clear the counter.
  - From HOLD or REPEAT: key release, or both keys pressed, -> IDLE with counter cleared.
- at_max/at_min are registered and track fword in the same cycle fword updates.

Test Plan:
(Use FWORD_UNIT=100, INIT=100, MIN=100, MAX=1000, REPEAT_DLY=8, REPEAT_PER=4, WAVE_NUM=3.)
1. Reset, then a single plus pulse -> fword 100->200 one cycle after key falls; fword_upd one pulse; at_min 1->0.
2. step_idx=1 (one key_step press), then plus x9 -> fword saturates at 1000 (200 + 10x... clamped); at_max=1; last press gives no fword_upd. Then minus x20 -> clamps at 100, at_min=1.
3. Hold plus continuously from fword=100 with step x1 -> +100 at press, next +100 8 cycles later, then +100 every 4 cycles; release -> increments stop immediately.
4. key_wave pressed 4 times -> wave_sel 1, 2, 0, 1. Same cycle as a plus press -> both wave_sel and fword update.
5. Plus and minus held simultaneously for 20 cycles -> fword unchanged, no fword_upd, no repeat.
6. Assert rst_n=0 for one cycle during REPEAT while plus stays held -> fword=100, wave_sel=0, step_idx=0. No increment until plus is released and pressed again.
